tmds_align_ctrl: RTL

TMDS_ALIGN_CTRL -- requirements
Module: tmds_align_ctrl

---
 rtl/tmds_pkg.sv | 29 ++
 rtl/tmds_ctrl_token_detect.sv | 16 +
 rtl/tmds_align_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-period tokens and alignment state encoding.
// Also used by the 8b10b decoder.
package tmds_pkg;

    localparam int NUM_CH = 3;

    localparam logic [9:0] TMDS_CTRL_0 = 10'h354;
    localparam logic [9:0] TMDS_CTRL_1 = 10'h0AB;
    localparam logic [9:0] TMDS_CTRL_2 = 10'h154;
    localparam logic [9:0] TMDS_CTRL_3 = 10'h2AB;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } align_state_t;

    function automatic logic is_ctrl_token(input logic [9:0] w);
        return (w == TMDS_CTRL_0) || (w == TMDS_CTRL_1) ||
               (w == TMDS_CTRL_2) || (w == TMDS_CTRL_3);
    endfunction

    // Deserializer has five sample phases; stepping past the last wraps to 0.
    function automatic logic [2:0] phase_next(input logic [2:0] p);
        return (p >= 3'd4) ? 3'd0 : p + 3'd1;
    endfunction

endpackage

// File: rtl/tmds_ctrl_token_detect.sv
// Per-channel control-token detector; flag is registered one cycle after the word.
module tmds_ctrl_token_detect
    import tmds_pkg::*;
(
    input  logic       hdmi_clk,
    input  logic       reset,
    input  logic [9:0] d,
    output logic       tok
);

    always_ff @(posedge hdmi_clk or posedge reset) begin
        if (reset) tok <= 1'b0;
        else       tok <= is_ctrl_token(d);
    end

endmodule

// File: rtl/tmds_align_ctrl.sv
// TMDS word-alignment controller: steps the deserializer phase until control
// periods appear on all channels, verifies them, and tracks loss of lock.
module tmds_align_ctrl
    import tmds_pkg::*;
#(
    parameter int SEARCH_TIMEOUT = 65536,
    parameter int MIN_RUN        = 8,
    parameter int LOCK_COUNT     = 4,
    parameter int LOSS_COUNT     = 3
) (
    input  logic       hdmi_clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic [9:0] d0,
    input  logic [9:0] d1,
    input  logic [9:0] d2,
    output logic [2:0] phase,
    output logic       phase_step,
    output logic       aligned,
    output logic [1:0] state,
    output logic [7:0] relock_count
);

    localparam int TW = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
    localparam int RW = $clog2(MIN_RUN + 1);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(LOSS_COUNT + 1);

    logic [NUM_CH-1:0][9:0] d_ch;
    logic [NUM_CH-1:0]      tok;
    logic                   all_tok;

    assign d_ch    = {d2, d1, d0};
    assign all_tok = &tok;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        tmds_ctrl_token_detect u_det (
            .hdmi_clk (hdmi_clk),
            .reset    (reset),
            .d        (d_ch[c]),
            .tok      (tok[c])
        );
    end

    // Run counter saturates at MIN_RUN so a long control period yields one event.
    logic [RW-1:0] run_q;
    logic          period_ev;

    assign period_ev = all_tok && (run_q == RW'(MIN_RUN - 1));

    always_ff @(posedge hdmi_clk or posedge reset) begin
        if (reset)                      run_q <= '0;
        else if (!all_tok)              run_q <= '0;
        else if (run_q != RW'(MIN_RUN)) run_q <= run_q + RW'(1);
    end

    logic pll_meta, pll_sync;

    always_ff @(posedge hdmi_clk or posedge reset) begin
        if (reset) begin
            pll_meta <= 1'b0;
            pll_sync <= 1'b0;
        end else begin
            pll_meta <= pll_locked;
            pll_sync <= pll_meta;
        end
    end

    align_state_t  state_q, state_nxt;
    logic [TW-1:0] timer_q, timer_nxt;
    logic [GW-1:0] good_q, good_nxt, good_inc;
    logic [MW-1:0] miss_q, miss_nxt, miss_inc;
    logic [2:0]    phase_nxt;
    logic          step_nxt;
    logic [7:0]    relock_nxt;
    logic          timeout;

    assign timeout  = (timer_q == TW'(SEARCH_TIMEOUT - 1));
    assign good_inc = good_q + GW'(1);
    assign miss_inc = miss_q + MW'(1);

    always_ff @(posedge hdmi_clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_nxt;
    end

    // Every active-state branch that can hit the timeout clears the timer,
    // so the default increment never wraps.
    always_comb begin
        state_nxt  = state_q;
        phase_nxt  = phase;
        step_nxt   = 1'b0;
        timer_nxt  = timer_q + TW'(1);
        good_nxt   = good_q;
        miss_nxt   = miss_q;
        relock_nxt = relock_count;
        if (!pll_sync) begin
            state_nxt = ST_IDLE;
            phase_nxt = '0;
            timer_nxt = '0;
            good_nxt  = '0;
            miss_nxt  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    phase_nxt = '0;
                    timer_nxt = '0;
                    state_nxt = ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (period_ev) begin
                        state_nxt = ST_VERIFY;
                        good_nxt  = GW'(1);
                        timer_nxt = '0;
                    end else if (timeout) begin
                        phase_nxt = phase_next(phase);
                        step_nxt  = 1'b1;
                        timer_nxt = '0;
                    end
                end
                ST_VERIFY: begin
                    if (period_ev) begin
                        good_nxt  = good_inc;
                        timer_nxt = '0;
                        if (good_inc == GW'(LOCK_COUNT)) begin
                            state_nxt = ST_LOCKED;
                            miss_nxt  = '0;
                        end
                    end else if (timeout) begin
                        state_nxt = ST_SEARCH;
                        phase_nxt = phase_next(phase);
                        step_nxt  = 1'b1;
                        timer_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    if (period_ev) begin
                        timer_nxt = '0;
                        miss_nxt  = '0;
                    end else if (timeout) begin
                        miss_nxt  = miss_inc;
                        timer_nxt = '0;
                        if (miss_inc == MW'(LOSS_COUNT)) begin
                            state_nxt  = ST_SEARCH;
                            phase_nxt  = phase_next(phase);
                            step_nxt   = 1'b1;
                            relock_nxt = (relock_count == 8'hFF) ? relock_count
                                                                 : relock_count + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge hdmi_clk or posedge reset) begin
        if (reset) begin
            timer_q      <= '0;
            good_q       <= '0;
            miss_q       <= '0;
            phase        <= '0;
            phase_step   <= 1'b0;
            relock_count <= '0;
        end else begin
            timer_q      <= timer_nxt;
            good_q       <= good_nxt;
            miss_q       <= miss_nxt;
            phase        <= phase_nxt;
            phase_step   <= step_nxt;
            relock_count <= relock_nxt;
        end
    end

    always_comb begin
        state   = state_q;
        aligned = (state_q == ST_LOCKED);
    end

endmodule
